uart_receiver: RTL

Receive half of the UART: deserialises an asynchronous serial line into bytes with 16x oversampling, mid-bit sampling, even parity and single stop bit. Sits beside the transmitter inside `uart` and drives the `Rx_*` outputs that higher-level FSMs poll for completed bytes. Frame format: 1 start (0), 8 data LSB-first, 1 even-parity, 1 stop (1).

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/baud_controller.sv | 48 ++++
 rtl/uart_receiver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, divisor table, receiver states.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DIV_W      = 16;

  typedef enum logic [2:0] {
    BAUD_300    = 3'b000,
    BAUD_1200   = 3'b001,
    BAUD_4800   = 3'b010,
    BAUD_9600   = 3'b011,
    BAUD_19200  = 3'b100,
    BAUD_38400  = 3'b101,
    BAUD_57600  = 3'b110,
    BAUD_115200 = 3'b111
  } baud_sel_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic int unsigned baud_rate(baud_sel_e sel);
    case (sel)
      BAUD_300:   return 300;
      BAUD_1200:  return 1200;
      BAUD_4800:  return 4800;
      BAUD_9600:  return 9600;
      BAUD_19200: return 19200;
      BAUD_38400: return 38400;
      BAUD_57600: return 57600;
      default:    return 115200;
    endcase
  endfunction

  // Rounded CLK_HZ / (16 * baud); only ever evaluated on constants.
  function automatic logic [DIV_W-1:0] baud_divisor(int unsigned clk_hz, baud_sel_e sel);
    int unsigned rate;
    int unsigned div;
    rate = baud_rate(sel);
    div  = (clk_hz + 8 * rate) / (16 * rate);
    return div[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x oversampling tick generator; down-counter reloaded from a constant divisor table.
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       enable,
  input  logic       restart,
  output logic       tick
);

  localparam logic [DIV_W-1:0] DIV_TBL [8] = '{
    baud_divisor(CLK_HZ, BAUD_300),
    baud_divisor(CLK_HZ, BAUD_1200),
    baud_divisor(CLK_HZ, BAUD_4800),
    baud_divisor(CLK_HZ, BAUD_9600),
    baud_divisor(CLK_HZ, BAUD_19200),
    baud_divisor(CLK_HZ, BAUD_38400),
    baud_divisor(CLK_HZ, BAUD_57600),
    baud_divisor(CLK_HZ, BAUD_115200)
  };

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  assign reload = DIV_TBL[baud_select] - DIV_W'(1);

  // Restart reloads the full period so the first tick lands one divisor later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable || restart) begin
      cnt  <= reload;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= reload;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchroniser, frame FSM, shift register, even-parity and stop checks.
// 8N? no: 8 data + even parity + 1 stop, LSB first, sampled mid-bit at 16x oversampling.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  logic       rx_meta;
  logic       rxs;
  rx_state_e  state;
  logic [2:0] sel_q;
  logic [2:0] sel_eff;
  logic       start_det;
  logic       tick;
  logic [3:0] tcnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       par_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  assign start_det = (state == IDLE) && Rx_EN && !rxs;
  // The new rate must reach the divisor reload on the same edge it is latched.
  assign sel_eff   = start_det ? baud_select : sel_q;

  baud_controller #(
    .CLK_HZ(CLK_HZ)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .baud_select(sel_eff),
    .enable     (Rx_EN),
    .restart    (start_det),
    .tick       (tick)
  );

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | timing to mid start bit, rejects glitches
  // DATA   | sampling 8 data bits, LSB first
  // PARITY | sampling even-parity bit
  // STOP   | sampling stop bit, publishing byte or errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= 3'b000;
      tcnt      <= 4'd0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      par_err   <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      if (!Rx_EN) begin
        state     <= IDLE;
        Rx_PERROR <= 1'b0;
        Rx_FERROR <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              tcnt  <= 4'd0;
              sel_q <= baud_select;
            end
          end
          START: begin
            if (tick) begin
              if (tcnt == TICK_MID) begin
                tcnt <= 4'd0;
                // Errors persist through false starts; only a real frame clears them.
                if (!rxs) begin
                  state     <= DATA;
                  idx       <= 3'd0;
                  Rx_PERROR <= 1'b0;
                  Rx_FERROR <= 1'b0;
                end else begin
                  state <= IDLE;
                end
              end else begin
                tcnt <= tcnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
              if (tcnt == TICK_LAST) begin
                shreg[idx] <= rxs;
                idx        <= idx + 3'd1;
                if (idx == 3'd7) state <= PARITY;
              end
            end
          end
          PARITY: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
              if (tcnt == TICK_LAST) begin
                par_err <= rxs ^ (^shreg);
                state   <= STOP;
              end
            end
          end
          STOP: begin
            if (tick) begin
              tcnt <= tcnt + 4'd1;
              if (tcnt == TICK_LAST) begin
                state     <= IDLE;
                Rx_FERROR <= !rxs;
                Rx_PERROR <= par_err;
                if (rxs && !par_err) begin
                  Rx_DATA  <= shreg;
                  Rx_VALID <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
